fp_normalizer: RTL and testbench
================================

FP_NORMALIZER -- requirements
Module: fp_normalizer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_WIDTH, default 23, stored fraction width (hidden bit excluded).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input operand valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port sign_in  input  1  result sign, passed through unchanged.
REQ-008 SHALL have port exp_in  input  EXP_WIDTH  larger exponent from the alignment stage.
REQ-009 SHALL have port mant_sum  input  MANT_WIDTH+2  raw sum: [MANT_WIDTH+1] is carry, [MANT_WIDTH] is hidden, rest is fraction.
REQ-010 SHALL have port grs  input  3  guard, round and sticky bits below the mant_sum LSB.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have ports sign_out 1, exp_out EXP_WIDTH and mant_out MANT_WIDTH, all outputs; the normalized result with the hidden bit dropped.
REQ-014 SHALL have ports zero, overflow and underflow, each 1-bit output flags valid while out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, NORM, ROUND (only with the macro) and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; on in_valid&&in_ready the block registers the inputs and moves to NORM.
REQ-017 NORM, carry=1: shift right 1, exp+1, shifted-out bit ORed into sticky; if exp+1 == all-ones, overflow=1, exp_out=all-ones, mant_out=0.
REQ-018 NORM, carry=0 and mant_sum==0: zero=1, exp_out=0, mant_out=0, grs ignored.
REQ-019 NORM, carry=0 and nonzero: lzc = leading zeros of mant_sum[MANT_WIDTH:0]; if lzc<exp_in, shift left by lzc (grs shifts in first, then zeros) and exp_out=exp_in-lzc; otherwise underflow=1 and the result is flushed to zero with zero=1.
REQ-020 Without the macro, NORM SHALL go to DONE; out_valid SHALL rise 2 cycles after the input handshake.
REQ-021 DONE SHALL hold out_valid and all result outputs stable until out_ready=1, then return to IDLE in that cycle.
REQ-022 Exponent arithmetic SHALL use EXP_WIDTH+1 bits internally so that no wrap-around is silent.
REQ-023 Only one operand SHALL be in flight; throughput is one result per 3 cycles (4 with the macro) at zero backpressure.

Reset
REQ-024 When arst_n=0 the FSM SHALL go to IDLE and every output SHALL be 0 (including in_ready), regardless of clk.
REQ-025 Reset mid-operation SHALL discard the in-flight operand; after release, in_ready=1 on the first clk edge.

Configuration
REQ-026 Macro FP_NORM_ROUND_EN, when defined, SHALL add the ROUND state between NORM and DONE.
REQ-027 ROUND SHALL round to nearest, ties to even, using guard and (round|sticky).
REQ-028 A rounding carry out of the hidden bit SHALL renormalize: shift right 1, exp+1, with the REQ-017 overflow check.
REQ-029 With the macro, latency SHALL be 3 cycles.
REQ-030 Without the macro, grs SHALL be ignored (truncation) and latency SHALL be 2.

Structure
REQ-031 EXP_WIDTH and MANT_WIDTH defaults, the FSM state encoding, and the mant_sum bit-position constants SHALL live in shared package fpu_pkg.
REQ-032 The leading-zero count SHALL be a combinational sub-module fp_lzc, parameterized by width, with outputs count and all_zero.

Verification
REQ-033 Carry: mant_sum=25'h1800000, exp_in=127 -> exp_out=128, mant_out=23'h400000, flags 0, out_valid 2 cycles after the handshake.
REQ-034 Cancellation: mant_sum=25'h0000100, exp_in=100, grs=0 -> lzc=15, exp_out=85, mant_out=0.
REQ-035 Zero and overflow: mant_sum=0, exp_in=50 -> zero=1, exp_out=0; mant_sum=25'h1000000, exp_in=8'hFE -> overflow=1, exp_out=8'hFF, mant_out=0.
REQ-036 Underflow: mant_sum=25'h0000001, exp_in=10 -> underflow=1, zero=1, exp_out=0, mant_out=0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-038 Reset: assert arst_n=0 while in NORM -> all outputs 0 immediately, no result is emitted after release.
REQ-039 Rounding (macro on): mant_sum=25'h0FFFFFF, grs=3'b100, exp_in=127 -> ties-to-even round up, carry renormalizes to exp_out=128, mant_out=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default field widths, normalizer FSM encoding and
// mant_sum bit positions relative to MANT_WIDTH.
package fpu_pkg;

    localparam int EXP_WIDTH_DEF  = 8;
    localparam int MANT_WIDTH_DEF = 23;

    // ROUND is only reachable when FP_NORM_ROUND_EN is defined.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } norm_state_t;

    function automatic int carry_pos(input int mant_width);
        return mant_width + 1;
    endfunction

    function automatic int hidden_pos(input int mant_width);
        return mant_width;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; count == WIDTH when the input is all zero.
module fp_lzc #(
    parameter int WIDTH = 24,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             all_zero
);

    // Scan upward so the most significant set bit is the last one to win.
    always_comb begin
        count    = CW'(WIDTH);
        all_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count    = CW'(WIDTH - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalizer: carry/cancellation shift, zero/overflow/underflow flags.
// Optional round-to-nearest-even stage enabled by macro FP_NORM_ROUND_EN.
module fp_normalizer
    import fpu_pkg::*;
#(
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
    parameter int MANT_WIDTH = MANT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign_in,
    input  logic [EXP_WIDTH-1:0]  exp_in,
    input  logic [MANT_WIDTH+1:0] mant_sum,
    input  logic [2:0]            grs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sign_out,
    output logic [EXP_WIDTH-1:0]  exp_out,
    output logic [MANT_WIDTH-1:0] mant_out,
    output logic                  zero,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int EW     = EXP_WIDTH;
    localparam int MW     = MANT_WIDTH;
    localparam int XW     = EW + 1;
    localparam int LW     = $clog2(MW + 2);
    localparam int CARRY  = carry_pos(MW);
    localparam int HIDDEN = hidden_pos(MW);
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EW{1'b1}}};

    norm_state_t state, next_state;

    logic            sign_r;
    logic [XW-1:0]   exp_r;
    logic [MW+1:0]   mant_r;
    logic [2:0]      grs_r;
    logic            accept;

    logic [LW-1:0]   lzc;
    logic            lz_zero;
    logic [MW+3:0]   sh_l;
    logic [XW-1:0]   n_exp;
    logic [MW:0]     n_mant;
    logic [2:0]      n_grs;
    logic            n_zero, n_ovf, n_unf;

    assign accept = in_valid && in_ready;

    fp_lzc #(.WIDTH(MW + 1), .CW(LW)) u_lzc (
        .data     (mant_r[HIDDEN:0]),
        .count    (lzc),
        .all_zero (lz_zero)
    );

    // Exponent math runs one bit wider than the field so an increment past
    // all-ones or a subtract below zero is visible instead of wrapping.
    always_comb begin
        n_exp  = exp_r;
        n_mant = mant_r[HIDDEN:0];
        n_grs  = grs_r;
        n_zero = 1'b0;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        sh_l   = {mant_r[HIDDEN:0], grs_r} << lzc;
        if (mant_r[CARRY]) begin
            n_exp  = exp_r + 1'b1;
            n_mant = mant_r[CARRY:1];
            n_grs  = {mant_r[0], grs_r[2], grs_r[1] | grs_r[0]};
            if (n_exp >= EXP_MAX) begin
                n_ovf  = 1'b1;
                n_exp  = EXP_MAX;
                n_mant = '0;
                n_grs  = '0;
            end
        end else if (lz_zero) begin
            n_zero = 1'b1;
            n_exp  = '0;
            n_mant = '0;
            n_grs  = '0;
        end else if (XW'(lzc) < exp_r) begin
            n_exp  = exp_r - XW'(lzc);
            n_mant = sh_l[MW+3:3];
            n_grs  = sh_l[2:0];
        end else begin
            n_unf  = 1'b1;
            n_zero = 1'b1;
            n_exp  = '0;
            n_mant = '0;
            n_grs  = '0;
        end
    end

`ifdef FP_NORM_ROUND_EN
    logic [XW-1:0]   r_exp;
    logic [MW:0]     r_mant;
    logic [2:0]      r_grs;
    logic            r_zero, r_ovf, r_unf;
    logic            rnd_up;
    logic [MW+1:0]   rnd_sum;
    logic [XW-1:0]   f_exp;
    logic [MW:0]     f_mant;
    logic            f_ovf;

    // Ties-to-even: round up on guard when round|sticky is set or the LSB is odd.
    always_comb begin
        rnd_up  = r_grs[2] & (r_grs[1] | r_grs[0] | r_mant[0]);
        rnd_sum = {1'b0, r_mant} + (MW+2)'(rnd_up);
        f_exp   = r_exp;
        f_mant  = rnd_sum[MW:0];
        f_ovf   = r_ovf;
        if (rnd_sum[MW+1]) begin
            f_exp  = r_exp + 1'b1;
            f_mant = rnd_sum[MW+1:1];
            if (f_exp >= EXP_MAX) begin
                f_ovf  = 1'b1;
                f_exp  = EXP_MAX;
                f_mant = '0;
            end
        end
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept) next_state = NORM;
`ifdef FP_NORM_ROUND_EN
            NORM:  next_state = ROUND;
            ROUND: next_state = DONE;
`else
            NORM:  next_state = DONE;
`endif
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mant_r    <= '0;
            grs_r     <= '0;
            sign_out  <= 1'b0;
            exp_out   <= '0;
            mant_out  <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef FP_NORM_ROUND_EN
            r_exp     <= '0;
            r_mant    <= '0;
            r_grs     <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            if (accept) begin
                sign_r <= sign_in;
                exp_r  <= {1'b0, exp_in};
                mant_r <= mant_sum;
                grs_r  <= grs;
            end
`ifdef FP_NORM_ROUND_EN
            if (state == NORM) begin
                r_exp  <= n_exp;
                r_mant <= n_mant;
                r_grs  <= n_grs;
                r_zero <= n_zero;
                r_ovf  <= n_ovf;
                r_unf  <= n_unf;
            end
            if (state == ROUND) begin
                sign_out  <= sign_r;
                exp_out   <= f_exp[EW-1:0];
                mant_out  <= f_mant[MW-1:0];
                zero      <= r_zero;
                overflow  <= f_ovf;
                underflow <= r_unf;
            end
`else
            // Truncation: remaining guard/round/sticky bits are dropped.
            if (state == NORM) begin
                sign_out  <= sign_r;
                exp_out   <= n_exp[EW-1:0];
                mant_out  <= n_mant[MW-1:0];
                zero      <= n_zero;
                overflow  <= n_ovf;
                underflow <= n_unf;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed self-checking bench for fp_normalizer (default 8/23 widths).
module tb_fp_normalizer;

`ifdef FP_NORM_ROUND_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int PERIOD = LAT + 1;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_in = 1'b0;
    logic [7:0]  exp_in = '0;
    logic [24:0] mant_sum = '0;
    logic [2:0]  grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic [22:0] mant_out;
    logic        zero, overflow, underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_normalizer #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_sum  (mant_sum),
        .grs       (grs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .mant_out  (mant_out),
        .zero      (zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Drives one operand; lat counts cycles with the handshake cycle as 0.
    // Called at a negedge; returns at the negedge where out_valid is seen.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [2:0] g, output int lat);
        int n;
        sign_in = s; exp_in = e; mant_sum = m; grs = g; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, sign_out, exp_out, mant_out, zero, overflow, underflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b exp=%h mant=%h flags=%b%b%b, want all 0",
                     in_ready, out_valid, exp_out, mant_out, zero, overflow, underflow);
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_carry();
        int lat;
        send(1'b0, 8'd127, 25'h1800000, 3'b000, lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL carry_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (exp_out !== 8'd128) begin errors++; $display("FAIL carry_exp: got %0d want 128", exp_out); end
        checks++;
        if (mant_out !== 23'h400000) begin errors++; $display("FAIL carry_mant: got %h want 400000", mant_out); end
        checks++;
        if ({zero, overflow, underflow} !== 3'b000) begin
            errors++; $display("FAIL carry_flags: got %b want 000", {zero, overflow, underflow});
        end
        release_result();
    endtask

    task automatic test_cancel();
        int lat;
        send(1'b1, 8'd100, 25'h0000100, 3'b000, lat);
        checks++;
        if (exp_out !== 8'd85) begin errors++; $display("FAIL cancel_exp: got %0d want 85", exp_out); end
        checks++;
        if (mant_out !== 23'h0) begin errors++; $display("FAIL cancel_mant: got %h want 0", mant_out); end
        checks++;
        if (sign_out !== 1'b1) begin errors++; $display("FAIL cancel_sign: got %b want 1", sign_out); end
        release_result();
        // grs bits shift into the fraction LSBs on a left shift
        send(1'b0, 8'd20, 25'h0400000, 3'b101, lat);
        checks++;
        if (exp_out !== 8'd19) begin errors++; $display("FAIL grs_shift_exp: got %0d want 19", exp_out); end
        checks++;
        if (mant_out !== 23'h000001) begin errors++; $display("FAIL grs_shift_mant: got %h want 000001", mant_out); end
        release_result();
    endtask

    task automatic test_zero_overflow();
        int lat;
        send(1'b0, 8'd50, 25'h0000000, 3'b111, lat);
        checks++;
        if ({zero, overflow, underflow} !== 3'b100) begin
            errors++; $display("FAIL zero_flags: got %b want 100", {zero, overflow, underflow});
        end
        checks++;
        if ({exp_out, mant_out} !== '0) begin
            errors++; $display("FAIL zero_result: got exp=%h mant=%h want 0", exp_out, mant_out);
        end
        release_result();
        send(1'b0, 8'hFE, 25'h1000000, 3'b000, lat);
        checks++;
        if ({zero, overflow, underflow} !== 3'b010) begin
            errors++; $display("FAIL ovf_flags: got %b want 010", {zero, overflow, underflow});
        end
        checks++;
        if (exp_out !== 8'hFF) begin errors++; $display("FAIL ovf_exp: got %h want FF", exp_out); end
        checks++;
        if (mant_out !== 23'h0) begin errors++; $display("FAIL ovf_mant: got %h want 0", mant_out); end
        release_result();
    endtask

    task automatic test_underflow();
        int lat;
        send(1'b0, 8'd10, 25'h0000001, 3'b000, lat);
        checks++;
        if ({zero, overflow, underflow} !== 3'b101) begin
            errors++; $display("FAIL unf_flags: got %b want 101", {zero, overflow, underflow});
        end
        checks++;
        if ({exp_out, mant_out} !== '0) begin
            errors++; $display("FAIL unf_result: got exp=%h mant=%h want 0", exp_out, mant_out);
        end
        release_result();
    endtask

    task automatic test_round();
        int lat;
        send(1'b0, 8'd127, 25'h0FFFFFF, 3'b100, lat);
`ifdef FP_NORM_ROUND_EN
        checks++;
        if (exp_out !== 8'd128) begin errors++; $display("FAIL round_exp: got %0d want 128", exp_out); end
        checks++;
        if (mant_out !== 23'h0) begin errors++; $display("FAIL round_mant: got %h want 0", mant_out); end
`else
        checks++;
        if (exp_out !== 8'd127) begin errors++; $display("FAIL trunc_exp: got %0d want 127", exp_out); end
        checks++;
        if (mant_out !== 23'h7FFFFF) begin errors++; $display("FAIL trunc_mant: got %h want 7FFFFF", mant_out); end
`endif
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        send(1'b1, 8'd127, 25'h1800000, 3'b000, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sign_out !== 1'b1 ||
                exp_out !== 8'd128 || mant_out !== 23'h400000) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_release: got rdy/ov=%b want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_back_to_back();
        int rdy_cnt, ov_cnt;
        rdy_cnt = 0; ov_cnt = 0;
        sign_in = 1'b0; exp_in = 8'd127; mant_sum = 25'h0800000; grs = 3'b000;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (in_ready) rdy_cnt++;
            if (out_valid) ov_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (rdy_cnt != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", rdy_cnt); end
        checks++;
        if (ov_cnt != 3) begin errors++; $display("FAIL b2b_results: got %0d want 3", ov_cnt); end
        repeat (PERIOD) @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        sign_in = 1'b1; exp_in = 8'd127; mant_sum = 25'h1800000; grs = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sign_out, exp_out, mant_out, zero, overflow, underflow} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b ov=%b exp=%h mant=%h, want all 0",
                     in_ready, out_valid, exp_out, mant_out);
        end
        @(negedge clk);
        arst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_no_result: got %0d valid cycles want 0", seen); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_cancel();
        test_zero_overflow();
        test_underflow();
        test_round();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, want finish before 50000");
        $fatal(1);
    end

endmodule
